reg_file_scoreboard: RTL and testbench
======================================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count; SHALL be a power of two, minimum 4.
REQ-003 Parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-004 Derived localparam AW = $clog2(NUM_REGS); not overridable.
REQ-005 CLK  in  1  clock; all state updates on the rising edge.
REQ-006 RST_N  in  1  reset; asynchronous, active-low.
REQ-007 ADDR1  in  AW  read port 1 address.
REQ-008 ADDR2  in  AW  read port 2 address.
REQ-009 WA  in  AW  write address.
REQ-010 WD  in  DATA_W  write data.
REQ-011 REG_WRITE  in  1  write enable; also retires the in-flight producer of WA.
REQ-012 ISSUE  in  1  marks ISSUE_RD as having an in-flight producer.
REQ-013 ISSUE_RD  in  AW  destination register being issued.
REQ-014 RS1, RS2  out  DATA_W  read data, combinational.
REQ-015 BUSY1, BUSY2  out  1  the addressed register has an unretired producer.
REQ-016 HAZARD  out  1  BUSY1 OR BUSY2.
REQ-017 PENDING  out  AW+1  registered count of busy registers.

Function
REQ-018 Register 0 SHALL read as zero, SHALL ignore writes, and SHALL never be busy.
REQ-019 Write: on a rising edge with REG_WRITE=1 and WA!=0, reg[WA] <= WD.
REQ-020 Reads SHALL be asynchronous: RSn = reg[ADDRn].
REQ-021 BYPASS=1: when REG_WRITE=1, WA!=0 and WA==ADDRn in the same cycle, RSn = WD (combinational).
REQ-022 BYPASS=0: RSn returns the pre-edge value in that case; the new value is visible on the cycle after the write.
REQ-023 Busy set: on a rising edge with ISSUE=1 and ISSUE_RD!=0, busy[ISSUE_RD] <= 1.
REQ-024 Busy clear: on a rising edge with REG_WRITE=1 and WA!=0, busy[WA] <= 0.
REQ-025 Set and clear of the same register in the same cycle: set wins, so the register stays busy for the new producer.
REQ-026 BUSYn = busy[ADDRn] AND NOT (BYPASS AND REG_WRITE AND WA==ADDRn AND WA!=0 AND NOT(ISSUE AND ISSUE_RD==WA)).
REQ-027 BUSYn SHALL be 0 for ADDRn==0.
REQ-028 PENDING SHALL track popcount(busy) with zero-cycle lag; it is updated on the same edge as busy.
REQ-029 PENDING update per edge: +1 if the set targets a non-busy register; -1 if the clear targets a busy register that is not also being set; otherwise unchanged.
REQ-030 Setting an already-busy register, or clearing a non-busy register, SHALL leave PENDING unchanged.
REQ-031 PENDING SHALL never exceed NUM_REGS-1 and SHALL never underflow.
REQ-032 Reads, writes and busy updates on independent addresses SHALL all complete in the same cycle.

Reset
REQ-033 RST_N=0 SHALL immediately clear all registers to 0, all busy bits to 0 and PENDING to 0, regardless of CLK.
REQ-034 While RST_N=0, REG_WRITE and ISSUE SHALL be ignored, and RS1/RS2/BUSYn/HAZARD SHALL read 0.
REQ-035 A write or issue presented on the edge where RST_N deasserts SHALL take effect normally.

Verification
REQ-036 Write WA=5, WD=0xDEADBEEF, REG_WRITE=1, ADDR1=5, BYPASS=1 -> RS1=0xDEADBEEF in that same cycle; with BYPASS=0 -> RS1=0 in that cycle and 0xDEADBEEF the next cycle.
REQ-037 Write WA=0, WD=0xFFFFFFFF; then ISSUE_RD=0 -> RS1 at ADDR1=0 stays 0, BUSY1=0, PENDING=0.
REQ-038 Issue regs 3, 7, 3 on consecutive cycles -> PENDING 1, 2, 2; ADDR2=7 gives BUSY2=1 and HAZARD=1; then REG_WRITE WA=7 -> BUSY2=0 in that cycle (BYPASS=1) and PENDING=1 after the edge.
REQ-039 Busy reg 4; same cycle ISSUE_RD=4 and REG_WRITE WA=4, WD=0x11 -> reg4=0x11, busy[4]=1, PENDING unchanged.
REQ-040 Fill regs 1-31 with issues -> PENDING=31; assert RST_N=0 mid-cycle -> PENDING=0, all BUSY=0 and all reads 0 before the next edge.
REQ-041 Parameter sweep DATA_W=16, NUM_REGS=8 -> REQ-036 to REQ-040 repeated at the scaled widths; PENDING width is 4.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with a busy-bit scoreboard tracking in-flight producers.
// Register 0 is hardwired to zero and is never busy.
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     addr1,
    input  logic [AW-1:0]     addr2,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              reg_write,
    input  logic              issue,
    input  logic [AW-1:0]     issue_rd,
    output logic [DATA_W-1:0] rs1,
    output logic [DATA_W-1:0] rs2,
    output logic              busy1,
    output logic              busy2,
    output logic              hazard,
    output logic [AW:0]       pending
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic wr_en, iss_en, reissue, hit1, hit2, inc, dec;

    assign wr_en   = reg_write && wa != '0;
    assign iss_en  = issue && issue_rd != '0;
    // a same-cycle reissue of the retiring register keeps it busy
    assign reissue = iss_en && issue_rd == wa;
    assign hit1    = BYPASS != 0 && wr_en && wa == addr1;
    assign hit2    = BYPASS != 0 && wr_en && wa == addr2;
    assign inc     = iss_en && !busy[issue_rd];
    assign dec     = wr_en && busy[wa] && !reissue;

    assign rs1    = (!rst_n || addr1 == '0) ? '0 : hit1 ? wd : regs[addr1];
    assign rs2    = (!rst_n || addr2 == '0) ? '0 : hit2 ? wd : regs[addr2];
    assign busy1  = rst_n && busy[addr1] && !(hit1 && !reissue);
    assign busy2  = rst_n && busy[addr2] && !(hit2 && !reissue);
    assign hazard = busy1 || busy2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // the later set overrides the clear when both target one register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            pending <= '0;
        end else begin
            if (wr_en) busy[wa] <= 1'b0;
            if (iss_en) busy[issue_rd] <= 1'b1;
            pending <= pending + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
        end
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: checks bypass, no-bypass and 16-bit/8-register instances
// against a shared array-based reference model.
module tb_reg_file_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  addr1, addr2, wa, issue_rd;
    logic [31:0] wd;
    logic        reg_write, issue;

    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic [15:0] c_rs1, c_rs2;
    logic        a_b1, a_b2, a_hz, b_b1, b_b2, b_hz, c_b1, c_b2, c_hz;
    logic [5:0]  a_pend, b_pend;
    logic [3:0]  c_pend;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .addr1(addr1), .addr2(addr2), .wa(wa), .wd(wd),
        .reg_write(reg_write), .issue(issue), .issue_rd(issue_rd),
        .rs1(a_rs1), .rs2(a_rs2), .busy1(a_b1), .busy2(a_b2), .hazard(a_hz), .pending(a_pend));

    reg_file_scoreboard #(.DATA_W(32), .NUM_REGS(32), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .addr1(addr1), .addr2(addr2), .wa(wa), .wd(wd),
        .reg_write(reg_write), .issue(issue), .issue_rd(issue_rd),
        .rs1(b_rs1), .rs2(b_rs2), .busy1(b_b1), .busy2(b_b2), .hazard(b_hz), .pending(b_pend));

    reg_file_scoreboard #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .addr1(addr1[2:0]), .addr2(addr2[2:0]), .wa(wa[2:0]),
        .wd(wd[15:0]), .reg_write(reg_write), .issue(issue), .issue_rd(issue_rd[2:0]),
        .rs1(c_rs1), .rs2(c_rs2), .busy1(c_b1), .busy2(c_b2), .hazard(c_hz), .pending(c_pend));

    // model index 0: 32 x 32-bit file, index 1: 8 x 16-bit file
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    function automatic int nr(int k);
        return k != 0 ? 8 : 32;
    endfunction

    function automatic logic [31:0] dmask(int k);
        return k != 0 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = '0;
                m_busy[k][i] = 0;
            end
    endtask

    task automatic model_edge();
        int w, r;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            w = int'(wa) % nr(k);
            r = int'(issue_rd) % nr(k);
            if (reg_write && w != 0) begin
                m_reg[k][w]  = wd & dmask(k);
                m_busy[k][w] = 0;
            end
            if (issue && r != 0) m_busy[k][r] = 1;
        end
    endtask

    function automatic logic [31:0] e_rs(int k, logic [4:0] ad, bit byp);
        int a = int'(ad) % nr(k);
        int w = int'(wa) % nr(k);
        if (!rst_n || a == 0) return '0;
        if (byp && reg_write && w == a) return wd & dmask(k);
        return m_reg[k][a];
    endfunction

    function automatic logic e_busy(int k, logic [4:0] ad, bit byp);
        int a = int'(ad) % nr(k);
        int w = int'(wa) % nr(k);
        int r = int'(issue_rd) % nr(k);
        if (!rst_n || a == 0) return 1'b0;
        if (byp && reg_write && w == a && !(issue && r == w)) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [5:0] e_pend(int k);
        int n = 0;
        for (int i = 0; i < nr(k); i++) n += int'(m_busy[k][i]);
        return 6'(n);
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 0; issue = 0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 0; reg_write = 1; wa = 5; wd = 32'hCAFE_F00D; addr1 = 5; addr2 = 5;
        issue = 1; issue_rd = 5;
        #1;
        checks += 4;
        if (a_rs1 !== 32'h0) begin errors++; $display("FAIL reset_rs1: got %h want 0", a_rs1); end
        if (a_b1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", a_b1); end
        if (a_hz !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b want 0", a_hz); end
        if (a_pend !== 6'd0 || c_pend !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d/%0d want 0", a_pend, c_pend); end
        step();
        idle(); rst_n = 1;
        #1;
        checks += 2;
        if (a_rs1 !== 32'h0 || b_rs1 !== 32'h0) begin errors++; $display("FAIL reset_ignore_write: got %h/%h want 0", a_rs1, b_rs1); end
        if (a_pend !== 6'd0 || a_b1 !== 1'b0) begin errors++; $display("FAIL reset_ignore_issue: got pend %0d busy %b want 0/0", a_pend, a_b1); end
    endtask

    task automatic test_bypass();
        reg_write = 1; wa = 5; wd = 32'hDEAD_BEEF; addr1 = 5; addr2 = 0;
        #1;
        checks += 3;
        if (a_rs1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h want deadbeef", a_rs1); end
        if (b_rs1 !== 32'h0) begin errors++; $display("FAIL nobypass_same_cycle: got %h want 0", b_rs1); end
        if (c_rs1 !== 16'hBEEF) begin errors++; $display("FAIL bypass16_same_cycle: got %h want beef", c_rs1); end
        step();
        idle();
        #1;
        checks += 2;
        if (b_rs1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nobypass_next_cycle: got %h want deadbeef", b_rs1); end
        if (a_rs1 !== 32'hDEAD_BEEF || c_rs1 !== 16'hBEEF) begin errors++; $display("FAIL bypass_stored: got %h/%h want deadbeef/beef", a_rs1, c_rs1); end
    endtask

    task automatic test_reg_zero();
        reg_write = 1; wa = 0; wd = 32'hFFFF_FFFF; addr1 = 0;
        step();
        idle(); issue = 1; issue_rd = 0;
        step();
        idle();
        #1;
        checks += 3;
        if (a_rs1 !== 32'h0 || b_rs1 !== 32'h0 || c_rs1 !== 16'h0) begin errors++; $display("FAIL zero_read: got %h/%h/%h want 0", a_rs1, b_rs1, c_rs1); end
        if (a_b1 !== 1'b0 || c_b1 !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b/%b want 0", a_b1, c_b1); end
        if (a_pend !== 6'd0 || c_pend !== 4'd0) begin errors++; $display("FAIL zero_pending: got %0d/%0d want 0", a_pend, c_pend); end
    endtask

    task automatic test_issue();
        logic [5:0] want [3] = '{6'd1, 6'd2, 6'd2};
        logic [4:0] rd   [3] = '{5'd3, 5'd7, 5'd3};
        for (int i = 0; i < 3; i++) begin
            issue = 1; issue_rd = rd[i];
            step();
            checks++;
            if (a_pend !== want[i] || 6'(c_pend) !== want[i]) begin errors++; $display("FAIL issue_pending_%0d: got %0d/%0d want %0d", i, a_pend, c_pend, want[i]); end
        end
        idle(); addr2 = 7; addr1 = 0;
        #1;
        checks += 2;
        if (a_b2 !== 1'b1 || c_b2 !== 1'b1) begin errors++; $display("FAIL issue_busy2: got %b/%b want 1", a_b2, c_b2); end
        if (a_hz !== 1'b1) begin errors++; $display("FAIL issue_hazard: got %b want 1", a_hz); end
        reg_write = 1; wa = 7; wd = 32'h1234_5678;
        #1;
        checks += 2;
        if (a_b2 !== 1'b0 || a_hz !== 1'b0) begin errors++; $display("FAIL retire_bypass_busy: got %b hz %b want 0", a_b2, a_hz); end
        if (b_b2 !== 1'b1) begin errors++; $display("FAIL retire_nobypass_busy: got %b want 1", b_b2); end
        step();
        idle();
        #1;
        checks++;
        if (a_pend !== 6'd1 || b_pend !== 6'd1 || c_pend !== 4'd1) begin errors++; $display("FAIL retire_pending: got %0d/%0d/%0d want 1", a_pend, b_pend, c_pend); end
    endtask

    task automatic test_set_clear();
        issue = 1; issue_rd = 4;
        step();
        issue = 1; issue_rd = 4; reg_write = 1; wa = 4; wd = 32'h11; addr1 = 4;
        #1;
        checks++;
        if (a_b1 !== 1'b1) begin errors++; $display("FAIL setclr_busy_same_cycle: got %b want 1", a_b1); end
        step();
        idle();
        #1;
        checks += 3;
        if (a_rs1 !== 32'h11 || c_rs1 !== 16'h11) begin errors++; $display("FAIL setclr_data: got %h/%h want 11", a_rs1, c_rs1); end
        if (a_b1 !== 1'b1 || c_b1 !== 1'b1) begin errors++; $display("FAIL setclr_busy: got %b/%b want 1", a_b1, c_b1); end
        if (a_pend !== 6'd2 || c_pend !== 4'd2) begin errors++; $display("FAIL setclr_pending: got %0d/%0d want 2", a_pend, c_pend); end
    endtask

    task automatic test_fill_reset();
        for (int r = 1; r < 32; r++) begin
            issue = 1; issue_rd = 5'(r);
            step();
        end
        idle();
        #1;
        checks++;
        if (a_pend !== 6'd31 || c_pend !== 4'd7) begin errors++; $display("FAIL fill_pending: got %0d/%0d want 31/7", a_pend, c_pend); end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (a_pend !== 6'd0 || b_pend !== 6'd0 || c_pend !== 4'd0) begin errors++; $display("FAIL async_reset_pending: got %0d/%0d/%0d want 0", a_pend, b_pend, c_pend); end
        for (int r = 0; r < 32; r++) begin
            addr1 = 5'(r); addr2 = 5'(r);
            #0.1;
            checks++;
            if (a_rs1 !== 32'h0 || a_b1 !== 1'b0 || a_hz !== 1'b0 || c_rs2 !== 16'h0 || c_b2 !== 1'b0) begin
                errors++; $display("FAIL async_reset_reg%0d: rs %h busy %b hz %b rs16 %h busy16 %b want all 0", r, a_rs1, a_b1, a_hz, c_rs2, c_b2);
            end
        end
        rst_n = 1;
        #1;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_n     = $urandom_range(0, 63) != 0;
            reg_write = $urandom_range(0, 2) == 0;
            issue     = $urandom_range(0, 1) == 1;
            wd        = $urandom;
            wa        = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            issue_rd  = $urandom_range(0, 3) == 0 ? wa : 5'($urandom_range(0, 31));
            addr1     = $urandom_range(0, 3) == 0 ? wa : 5'($urandom_range(0, 31));
            addr2     = 5'($urandom_range(0, 7));
            if (!rst_n) model_reset();
            #1;
            checks += 3;
            if ({a_rs1, a_rs2, a_b1, a_b2, a_hz, a_pend} !==
                {e_rs(0, addr1, 1), e_rs(0, addr2, 1), e_busy(0, addr1, 1), e_busy(0, addr2, 1),
                 e_busy(0, addr1, 1) | e_busy(0, addr2, 1), e_pend(0)}) begin
                errors++; $display("FAIL rand_bypass cyc %0d: got %h %h %b%b%b %0d want %h %h %b%b %0d", cyc,
                    a_rs1, a_rs2, a_b1, a_b2, a_hz, a_pend, e_rs(0, addr1, 1), e_rs(0, addr2, 1),
                    e_busy(0, addr1, 1), e_busy(0, addr2, 1), e_pend(0));
            end
            if ({b_rs1, b_rs2, b_b1, b_b2, b_hz, b_pend} !==
                {e_rs(0, addr1, 0), e_rs(0, addr2, 0), e_busy(0, addr1, 0), e_busy(0, addr2, 0),
                 e_busy(0, addr1, 0) | e_busy(0, addr2, 0), e_pend(0)}) begin
                errors++; $display("FAIL rand_nobypass cyc %0d: got %h %h %b%b%b %0d want %h %h %b%b %0d", cyc,
                    b_rs1, b_rs2, b_b1, b_b2, b_hz, b_pend, e_rs(0, addr1, 0), e_rs(0, addr2, 0),
                    e_busy(0, addr1, 0), e_busy(0, addr2, 0), e_pend(0));
            end
            if ({c_rs1, c_rs2, c_b1, c_b2, c_hz, c_pend} !==
                {16'(e_rs(1, addr1, 1)), 16'(e_rs(1, addr2, 1)), e_busy(1, addr1, 1), e_busy(1, addr2, 1),
                 e_busy(1, addr1, 1) | e_busy(1, addr2, 1), 4'(e_pend(1))}) begin
                errors++; $display("FAIL rand_small cyc %0d: got %h %h %b%b%b %0d want %h %h %b%b %0d", cyc,
                    c_rs1, c_rs2, c_b1, c_b2, c_hz, c_pend, 16'(e_rs(1, addr1, 1)), 16'(e_rs(1, addr2, 1)),
                    e_busy(1, addr1, 1), e_busy(1, addr2, 1), e_pend(1));
            end
            step();
        end
        rst_n = 1;
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_reg_zero();
        test_issue();
        test_set_clear();
        test_fill_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
